midi_status_decoder: RTL

MIDI_STATUS_DECODER -- requirements
Module: midi_status_decoder

---
 rtl/midi_status_decoder_pkg.sv | 43 ++++
 rtl/midi_status_decoder.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/midi_status_decoder_pkg.sv
// -----------------------------------------------------------------------------
// midi_status_decoder_pkg
// Shared definitions for the MIDI status decoder: the parser state encoding,
// the status-class nibble constants, the system byte constants and the
// class-flag bundle driven onto the is_st_* outputs.
// -----------------------------------------------------------------------------
package midi_status_decoder_pkg;

  typedef enum logic [1:0] {
    NO_STATUS = 2'd0,
    WAIT_D1   = 2'd1,
    WAIT_D2   = 2'd2,
    SYSEX     = 2'd3
  } state_e;

  // Channel-voice status classes (upper nibble of the status byte)
  localparam logic [3:0] CLS_NOTE_OFF = 4'h8;
  localparam logic [3:0] CLS_NOTE_ON  = 4'h9;
  localparam logic [3:0] CLS_POLY_AT  = 4'hA;
  localparam logic [3:0] CLS_CTRL     = 4'hB;
  localparam logic [3:0] CLS_PGM      = 4'hC;
  localparam logic [3:0] CLS_CHAN_AT  = 4'hD;
  localparam logic [3:0] CLS_PITCH    = 4'hE;

  // System bytes
  localparam logic [7:0] SYS_SOX    = 8'hF0;  // start of exclusive
  localparam logic [7:0] SYS_EOX    = 8'hF7;  // end of exclusive
  localparam logic [7:0] SYS_RT_MIN = 8'hF8;  // first realtime byte

  typedef struct packed {
    logic note_on;
    logic note_off;
    logic ctrl;
    logic pgm;
    logic sysex;
  } cls_flags_t;

  typedef struct packed {
    logic       three_byte;
    cls_flags_t flags;
  } cls_info_t;

endpackage

// File: rtl/midi_status_decoder.sv
// -----------------------------------------------------------------------------
// midi_status_decoder
// Parses a raw MIDI byte stream (running status, realtime filtering, sysex)
// and presents each accepted data byte with a one-cycle byteready strobe.
//
// Ports
//   CLOCK_50       in   single clock, rising edge
//   reset_reg_N    in   synchronous active-low reset
//   rx_valid       in   one-cycle strobe, rx_byte valid
//   rx_byte[7:0]   in   raw MIDI byte
//   midi_ch[3:0]   in   receive channel (only used when OMNI = 0)
//   byteready      out  one-cycle strobe, accepted byte on databyte
//   databyte[7:0]  out  last accepted data byte
//   is_data_byte   out  databyte is data byte 1 (or a sysex data byte)
//   is_velocity    out  databyte is data byte 2
//   is_st_*        out  current running status class
// -----------------------------------------------------------------------------
module midi_status_decoder
  import midi_status_decoder_pkg::*;
#(
  parameter int unsigned OMNI = 1
) (
  input  logic       CLOCK_50,
  input  logic       reset_reg_N,
  input  logic       rx_valid,
  input  logic [7:0] rx_byte,
  input  logic [3:0] midi_ch,
  output logic       byteready,
  output logic [7:0] databyte,
  output logic       is_data_byte,
  output logic       is_velocity,
  output logic       is_st_note_on,
  output logic       is_st_note_off,
  output logic       is_st_ctrl,
  output logic       is_st_pgm,
  output logic       is_st_sysex
);

  // Message length and reported class for a channel-voice status nibble.
  // Classes without a dedicated flag still need the correct length so the
  // running-status byte counting stays in step.
  function automatic cls_info_t decode_class(input logic [3:0] hi);
    cls_info_t info;
    info = '0;
    case (hi)
      CLS_NOTE_OFF: begin info.three_byte = 1'b1; info.flags.note_off = 1'b1; end
      CLS_NOTE_ON:  begin info.three_byte = 1'b1; info.flags.note_on  = 1'b1; end
      CLS_POLY_AT:  info.three_byte = 1'b1;
      CLS_CTRL:     begin info.three_byte = 1'b1; info.flags.ctrl     = 1'b1; end
      CLS_PGM:      info.flags.pgm = 1'b1;
      CLS_CHAN_AT:  info.three_byte = 1'b0;
      CLS_PITCH:    info.three_byte = 1'b1;
      default:      info = '0;
    endcase
    return info;
  endfunction

  state_e     state_q, state_d;
  logic       three_q, three_d;
  logic [3:0] chan_q, chan_d;
  logic       byteready_q, byteready_d;
  logic [7:0] databyte_q, databyte_d;
  logic       is_data_q, is_data_d;
  logic       is_vel_q, is_vel_d;
  cls_flags_t flags_q, flags_d;

  cls_info_t  status_info;
  logic       status_match;
  logic       data_match;

  assign status_info  = decode_class(rx_byte[7:4]);
  // A status byte is judged on its own channel nibble; data bytes are judged
  // on the channel latched from their status byte.
  assign status_match = (OMNI != 0) || (rx_byte[3:0] == midi_ch);
  assign data_match   = (OMNI != 0) || (chan_q == midi_ch);

  always_comb begin
    state_d     = state_q;
    three_d     = three_q;
    chan_d      = chan_q;
    byteready_d = 1'b0;
    databyte_d  = databyte_q;
    is_data_d   = is_data_q;
    is_vel_d    = is_vel_q;
    flags_d     = flags_q;

    // Realtime bytes are invisible to the parser.
    if (rx_valid && (rx_byte < SYS_RT_MIN)) begin
      if (rx_byte[7]) begin
        if (rx_byte < SYS_SOX) begin
          // Length tracking follows every channel; outputs only follow ours.
          state_d = WAIT_D1;
          three_d = status_info.three_byte;
          chan_d  = rx_byte[3:0];
          if (status_match) begin
            flags_d   = status_info.flags;
            is_data_d = 1'b0;
            is_vel_d  = 1'b0;
          end
        end else if (rx_byte == SYS_SOX) begin
          state_d       = SYSEX;
          flags_d       = '0;
          flags_d.sysex = 1'b1;
          is_data_d     = 1'b0;
          is_vel_d      = 1'b0;
        end else begin
          // F1-F7: system common / EOX cancel running status.
          state_d = NO_STATUS;
          flags_d = '0;
        end
      end else begin
        case (state_q)
          WAIT_D1: begin
            if (data_match) begin
              byteready_d = 1'b1;
              databyte_d  = rx_byte;
              is_data_d   = 1'b1;
              is_vel_d    = 1'b0;
            end
            state_d = three_q ? WAIT_D2 : WAIT_D1;
          end
          WAIT_D2: begin
            if (data_match) begin
              byteready_d = 1'b1;
              databyte_d  = rx_byte;
              is_data_d   = 1'b0;
              is_vel_d    = 1'b1;
            end
            state_d = WAIT_D1;
          end
          SYSEX: begin
            byteready_d = 1'b1;
            databyte_d  = rx_byte;
            is_data_d   = 1'b1;
            is_vel_d    = 1'b0;
          end
          default: state_d = NO_STATUS;
        endcase
      end
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (!reset_reg_N) begin
      state_q     <= NO_STATUS;
      three_q     <= 1'b0;
      chan_q      <= 4'h0;
      byteready_q <= 1'b0;
      databyte_q  <= 8'h00;
      is_data_q   <= 1'b0;
      is_vel_q    <= 1'b0;
      flags_q     <= '0;
    end else begin
      state_q     <= state_d;
      three_q     <= three_d;
      chan_q      <= chan_d;
      byteready_q <= byteready_d;
      databyte_q  <= databyte_d;
      is_data_q   <= is_data_d;
      is_vel_q    <= is_vel_d;
      flags_q     <= flags_d;
    end
  end

  assign byteready      = byteready_q;
  assign databyte       = databyte_q;
  assign is_data_byte   = is_data_q;
  assign is_velocity    = is_vel_q;
  assign is_st_note_on  = flags_q.note_on;
  assign is_st_note_off = flags_q.note_off;
  assign is_st_ctrl     = flags_q.ctrl;
  assign is_st_pgm      = flags_q.pgm;
  assign is_st_sysex    = flags_q.sysex;

endmodule
